instr_fetch_unit: RTL and testbench

Instruction fetch stage that sources the instruction word, its PC and PC+4 consumed by the IF/ID pipeline latch. It owns the fetch PC, issues word requests to instruction memory over a req/ack + response-valid interface, buffers returned words, and presents them to the IF/ID latch with a valid flag. It handles downstream STALL, branch/jump redirects, and discarding of in-flight responses after a redirect.

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction memory and
// presents them to the IF/ID latch. Define IFETCH_PREFETCH_EN for a 2-entry prefetch buffer.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        Request_Alt_PC,
   input  logic [31:0] Alt_PC,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ack,
   input  logic        IMem_Rsp_Valid,
   input  logic [31:0] IMem_Rsp_Data,
   output logic [31:0] Instr1_IF,
   output logic [31:0] Instr_PC_IF,
   output logic [31:0] Instr_PC_Plus4_IF,
   output logic        Instr_Valid_IF
);

`ifdef IFETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [2:0] DEPTH_W = 3'(DEPTH);

   logic [31:0] fpc_q, fpc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  drop_q, drop_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] tag_q [DEPTH];
   logic [31:0] tag_d [DEPTH];
   logic [31:0] instr_q [DEPTH];
   logic [31:0] instr_d [DEPTH];
   logic [31:0] pc_q [DEPTH];
   logic [31:0] pc_d [DEPTH];

   logic        head_valid, consume, accept, rsp, keep;
   logic [2:0]  occ;
   logic [1:0]  tag_base, buf_base;
   logic        unused_alt_lsb;

   assign unused_alt_lsb = ^Alt_PC[1:0];

   always_comb begin
      head_valid = (cnt_q != 2'd0);
      consume    = head_valid && !STALL;
      // A head entry consumed on this edge frees its slot in time for the new request.
      occ        = 3'(out_q) + 3'(cnt_q) - 3'(consume);
      IMem_Req   = RESET && !Request_Alt_PC && (occ < DEPTH_W);
      IMem_Addr  = fpc_q;
      accept     = IMem_Req && IMem_Ack;
      rsp        = IMem_Rsp_Valid && (out_q != 2'd0);
      keep       = rsp && (drop_q == 2'd0) && !Request_Alt_PC;
   end

   always_comb begin
      fpc_d = fpc_q;
      if (Request_Alt_PC) begin
         fpc_d = {Alt_PC[31:2], 2'b00};
      end else if (accept) begin
         fpc_d = fpc_q + 32'd4;
      end

      out_d = out_q + 2'(accept) - 2'(rsp);

      // PC tags of outstanding requests, oldest at index 0.
      tag_d    = tag_q;
      tag_base = out_q - 2'(rsp);
      if (rsp) begin
         for (int i = 0; i + 1 < DEPTH; i++) tag_d[i] = tag_q[i + 1];
      end
      if (accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(tag_base)) tag_d[i] = fpc_q;
         end
      end

      drop_d = drop_q;
      if (Request_Alt_PC) begin
         drop_d = out_d;
      end else if (rsp && (drop_q != 2'd0)) begin
         drop_d = drop_q - 2'd1;
      end

      instr_d  = instr_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      buf_base = cnt_q - 2'(consume);
      if (Request_Alt_PC) begin
         cnt_d = 2'd0;
      end else begin
         if (consume) begin
            for (int i = 0; i + 1 < DEPTH; i++) begin
               instr_d[i] = instr_q[i + 1];
               pc_d[i]    = pc_q[i + 1];
            end
         end
         if (keep) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i == int'(buf_base)) begin
                  instr_d[i] = IMem_Rsp_Data;
                  pc_d[i]    = tag_q[0];
               end
            end
         end
         cnt_d = buf_base + 2'(keep);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fpc_q   <= RESET_PC;
         out_q   <= 2'd0;
         drop_q  <= 2'd0;
         cnt_q   <= 2'd0;
         tag_q   <= '{default: '0};
         instr_q <= '{default: '0};
         pc_q    <= '{default: '0};
      end else begin
         fpc_q   <= fpc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      Instr_Valid_IF    = head_valid;
      Instr1_IF         = 32'd0;
      Instr_PC_IF       = 32'd0;
      Instr_PC_Plus4_IF = 32'd0;
      if (head_valid) begin
         Instr1_IF         = instr_q[0];
         Instr_PC_IF       = pc_q[0];
         Instr_PC_Plus4_IF = pc_q[0] + 32'd4;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory of selectable latency.
module tb_instr_fetch_unit;
   localparam logic [31:0] K   = 32'h5A5A5A5A;
   localparam logic [31:0] RPC = 32'hBFC00000;
`ifdef IFETCH_PREFETCH_EN
   localparam int PF = 1;
`else
   localparam int PF = 0;
`endif

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        STALL = 1'b0;
   logic        Request_Alt_PC = 1'b0;
   logic [31:0] Alt_PC = 32'd0;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ack;
   logic        IMem_Rsp_Valid;
   logic [31:0] IMem_Rsp_Data;
   logic [31:0] Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;
   logic        Instr_Valid_IF;

   int errors = 0;
   int checks = 0;

   // Memory model: response arrives 'lat' edges after the accepting edge.
   int          lat = 1;
   logic        ack = 1'b1;
   logic        spur = 1'b0;
   logic [3:0]  pv;
   logic [31:0] pd [4];

   assign IMem_Ack       = ack;
   assign IMem_Rsp_Valid = pv[0] | spur;
   assign IMem_Rsp_Data  = pd[0];

   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pv <= 4'd0;
         for (int i = 0; i < 4; i++) pd[i] <= 32'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (i == lat - 1) begin
               pv[i] <= IMem_Req && IMem_Ack;
               pd[i] <= IMem_Addr ^ K;
            end else if (i < 3) begin
               pv[i] <= pv[(i + 1) % 4];
               pd[i] <= pd[(i + 1) % 4];
            end else begin
               pv[i] <= 1'b0;
            end
         end
      end
   end

   instr_fetch_unit dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .STALL            (STALL),
      .Request_Alt_PC   (Request_Alt_PC),
      .Alt_PC           (Alt_PC),
      .IMem_Req         (IMem_Req),
      .IMem_Addr        (IMem_Addr),
      .IMem_Ack         (IMem_Ack),
      .IMem_Rsp_Valid   (IMem_Rsp_Valid),
      .IMem_Rsp_Data    (IMem_Rsp_Data),
      .Instr1_IF        (Instr1_IF),
      .Instr_PC_IF      (Instr_PC_IF),
      .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
      .Instr_Valid_IF   (Instr_Valid_IF)
   );

   // Leaves the bench just after a negedge with RESET released (first post-reset cycle).
   task automatic do_reset(input int l);
      RESET = 1'b0;
      lat = l;
      STALL = 1'b0;
      Request_Alt_PC = 1'b0;
      spur = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (Instr_Valid_IF === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      @(negedge CLK);
      checks += 6;
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", Instr_Valid_IF); end
      if (Instr1_IF !== 32'd0) begin errors++; $display("FAIL rst_instr got %h want 0", Instr1_IF); end
      if (Instr_PC_IF !== 32'd0) begin errors++; $display("FAIL rst_pc got %h want 0", Instr_PC_IF); end
      if (Instr_PC_Plus4_IF !== 32'd0) begin errors++; $display("FAIL rst_pc4 got %h want 0", Instr_PC_Plus4_IF); end
      if (IMem_Req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", IMem_Req); end
      if (IMem_Addr !== RPC) begin errors++; $display("FAIL rst_addr got %h want %h", IMem_Addr, RPC); end
   endtask

   task automatic test_stream;
      bit          ev;
      logic [31:0] ep;
      do_reset(1);
      #1;
      checks += 2;
      if (IMem_Req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", IMem_Req); end
      if (IMem_Addr !== RPC) begin errors++; $display("FAIL first_addr got %h want %h", IMem_Addr, RPC); end
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         ev = (PF == 1) ? (c >= 2) : (c % 2 == 0);
         ep = RPC + 32'(4 * ((PF == 1) ? (c - 2) : (c / 2 - 1)));
         checks++;
         if (Instr_Valid_IF !== ev) begin
            errors++; $display("FAIL stream_valid c=%0d got %b want %b", c, Instr_Valid_IF, ev);
         end
         if (ev) begin
            checks += 3;
            if (Instr_PC_IF !== ep) begin errors++; $display("FAIL stream_pc c=%0d got %h want %h", c, Instr_PC_IF, ep); end
            if (Instr1_IF !== (ep ^ K)) begin errors++; $display("FAIL stream_instr c=%0d got %h want %h", c, Instr1_IF, ep ^ K); end
            if (Instr_PC_Plus4_IF !== ep + 32'd4) begin errors++; $display("FAIL stream_pc4 c=%0d got %h want %h", c, Instr_PC_Plus4_IF, ep + 32'd4); end
         end
      end
   endtask

   task automatic test_stall;
      bit          found;
      int          seen;
      logic [31:0] ep;
      do_reset(1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (Instr_Valid_IF === 1'b1 && Instr_PC_IF === 32'hBFC00008) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL stall_reach got 0 want 1"); end
      STALL = 1'b1;
      #1;
      checks++;
      if (IMem_Req !== 1'b0) begin errors++; $display("FAIL stall_req0 got %b want 0", IMem_Req); end
      for (int s = 0; s < 3; s++) begin
         @(negedge CLK);
         checks += 4;
         if (Instr_Valid_IF !== 1'b1) begin errors++; $display("FAIL stall_valid s=%0d got %b want 1", s, Instr_Valid_IF); end
         if (Instr_PC_IF !== 32'hBFC00008) begin errors++; $display("FAIL stall_pc s=%0d got %h want bfc00008", s, Instr_PC_IF); end
         if (Instr1_IF !== (32'hBFC00008 ^ K)) begin errors++; $display("FAIL stall_instr s=%0d got %h want %h", s, Instr1_IF, 32'hBFC00008 ^ K); end
         if (IMem_Req !== 1'b0) begin errors++; $display("FAIL stall_req s=%0d got %b want 0", s, IMem_Req); end
      end
      STALL = 1'b0;
      ep = 32'hBFC0000C;
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         @(negedge CLK);
         if (Instr_Valid_IF === 1'b1) begin
            checks++;
            if (Instr_PC_IF !== ep) begin errors++; $display("FAIL stall_resume n=%0d got %h want %h", seen, Instr_PC_IF, ep); end
            ep += 32'd4;
            seen++;
         end
      end
      checks++;
      if (seen != 3) begin errors++; $display("FAIL stall_resume_count got %0d want 3", seen); end
   endtask

   task automatic test_redirect;
      bit found;
      do_reset(3);
      repeat ((PF == 1) ? 2 : 1) @(negedge CLK);
      Request_Alt_PC = 1'b1;
      Alt_PC = 32'h80000003;
      #1;
      checks++;
      if (IMem_Req !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", IMem_Req); end
      @(negedge CLK);
      Request_Alt_PC = 1'b0;
      #1;
      checks += 2;
      if (IMem_Addr !== 32'h80000000) begin errors++; $display("FAIL redir_addr got %h want 80000000", IMem_Addr); end
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", Instr_Valid_IF); end
      wait_valid(30, found);
      checks += 4;
      if (!found) begin errors++; $display("FAIL redir_timeout got 0 want 1"); end
      if (Instr_PC_IF !== 32'h80000000) begin errors++; $display("FAIL redir_pc got %h want 80000000", Instr_PC_IF); end
      if (Instr_PC_Plus4_IF !== 32'h80000004) begin errors++; $display("FAIL redir_pc4 got %h want 80000004", Instr_PC_Plus4_IF); end
      if (Instr1_IF !== (32'h80000000 ^ K)) begin errors++; $display("FAIL redir_instr got %h want %h", Instr1_IF, 32'h80000000 ^ K); end
   endtask

   task automatic test_same_edge;
      bit found;
      do_reset(1);
      repeat ((PF == 1) ? 2 : 1) @(negedge CLK);
      Request_Alt_PC = 1'b1;
      Alt_PC = 32'h00001000;
      STALL = 1'b1;
      @(negedge CLK);
      Request_Alt_PC = 1'b0;
      STALL = 1'b0;
      #1;
      checks += 3;
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL same_valid got %b want 0", Instr_Valid_IF); end
      if (Instr1_IF !== 32'd0) begin errors++; $display("FAIL same_instr got %h want 0", Instr1_IF); end
      if (Instr_PC_IF !== 32'd0) begin errors++; $display("FAIL same_pc got %h want 0", Instr_PC_IF); end
      wait_valid(20, found);
      checks++;
      if (!found || Instr_PC_IF !== 32'h00001000) begin
         errors++; $display("FAIL same_target got %h found=%b want 00001000", Instr_PC_IF, found);
      end
      // Flush a held head entry while stalled; low address bits are masked.
      STALL = 1'b1;
      Request_Alt_PC = 1'b1;
      Alt_PC = 32'h00002006;
      @(negedge CLK);
      Request_Alt_PC = 1'b0;
      STALL = 1'b0;
      #1;
      checks++;
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL stall_flush got %b want 0", Instr_Valid_IF); end
      wait_valid(20, found);
      checks++;
      if (!found || Instr_PC_IF !== 32'h00002004) begin
         errors++; $display("FAIL stall_flush_target got %h found=%b want 00002004", Instr_PC_IF, found);
      end
   endtask

   task automatic test_back_to_back;
      bit found;
      do_reset(3);
      @(negedge CLK);
      Request_Alt_PC = 1'b1;
      Alt_PC = 32'h00000100;
      @(negedge CLK);
      Alt_PC = 32'h00000200;
      @(negedge CLK);
      Request_Alt_PC = 1'b0;
      #1;
      checks++;
      if (IMem_Addr !== 32'h00000200) begin errors++; $display("FAIL b2b_addr got %h want 00000200", IMem_Addr); end
      wait_valid(30, found);
      checks += 2;
      if (!found) begin errors++; $display("FAIL b2b_timeout got 0 want 1"); end
      if (Instr_PC_IF !== 32'h00000200) begin errors++; $display("FAIL b2b_pc got %h want 00000200", Instr_PC_IF); end
   endtask

   task automatic test_wrap;
      logic [31:0] ep [3];
      logic [31:0] e4 [3];
      int          seen;
      ep[0] = 32'hFFFFFFF8; ep[1] = 32'hFFFFFFFC; ep[2] = 32'h00000000;
      e4[0] = 32'hFFFFFFFC; e4[1] = 32'h00000000; e4[2] = 32'h00000004;
      do_reset(1);
      Request_Alt_PC = 1'b1;
      Alt_PC = 32'hFFFFFFF8;
      @(negedge CLK);
      Request_Alt_PC = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         @(negedge CLK);
         if (Instr_Valid_IF === 1'b1) begin
            checks += 2;
            if (Instr_PC_IF !== ep[seen]) begin errors++; $display("FAIL wrap_pc n=%0d got %h want %h", seen, Instr_PC_IF, ep[seen]); end
            if (Instr_PC_Plus4_IF !== e4[seen]) begin errors++; $display("FAIL wrap_pc4 n=%0d got %h want %h", seen, Instr_PC_Plus4_IF, e4[seen]); end
            seen++;
         end
      end
      checks++;
      if (seen != 3) begin errors++; $display("FAIL wrap_count got %0d want 3", seen); end
   endtask

   task automatic test_mid_reset;
      bit found;
      do_reset(3);
      STALL = 1'b1;
      wait_valid(20, found);
      repeat (PF) @(negedge CLK);
      checks++;
      if (!found) begin errors++; $display("FAIL mrst_fill got 0 want 1"); end
      #2;
      RESET = 1'b0;
      #1;
      checks += 6;
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", Instr_Valid_IF); end
      if (Instr1_IF !== 32'd0) begin errors++; $display("FAIL mrst_instr got %h want 0", Instr1_IF); end
      if (Instr_PC_IF !== 32'd0) begin errors++; $display("FAIL mrst_pc got %h want 0", Instr_PC_IF); end
      if (Instr_PC_Plus4_IF !== 32'd0) begin errors++; $display("FAIL mrst_pc4 got %h want 0", Instr_PC_Plus4_IF); end
      if (IMem_Req !== 1'b0) begin errors++; $display("FAIL mrst_req got %b want 0", IMem_Req); end
      if (IMem_Addr !== RPC) begin errors++; $display("FAIL mrst_addr got %h want %h", IMem_Addr, RPC); end
      do_reset(1);
      wait_valid(20, found);
      checks += 2;
      if (!found || Instr_PC_IF !== RPC) begin errors++; $display("FAIL mrst_restart_pc got %h found=%b want %h", Instr_PC_IF, found, RPC); end
      if (Instr1_IF !== (RPC ^ K)) begin errors++; $display("FAIL mrst_restart_instr got %h want %h", Instr1_IF, RPC ^ K); end
   endtask

   task automatic test_ack_wait;
      bit found;
      ack = 1'b0;
      do_reset(1);
      for (int s = 0; s < 3; s++) begin
         @(negedge CLK);
         checks += 3;
         if (IMem_Req !== 1'b1) begin errors++; $display("FAIL ack_req s=%0d got %b want 1", s, IMem_Req); end
         if (IMem_Addr !== RPC) begin errors++; $display("FAIL ack_addr s=%0d got %h want %h", s, IMem_Addr, RPC); end
         if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL ack_valid s=%0d got %b want 0", s, Instr_Valid_IF); end
      end
      // Spurious response with nothing outstanding must be ignored.
      spur = 1'b1;
      @(negedge CLK);
      spur = 1'b0;
      #1;
      checks++;
      if (Instr_Valid_IF !== 1'b0) begin errors++; $display("FAIL spur_valid got %b want 0", Instr_Valid_IF); end
      ack = 1'b1;
      wait_valid(20, found);
      checks++;
      if (!found || Instr_PC_IF !== RPC) begin errors++; $display("FAIL ack_first_pc got %h found=%b want %h", Instr_PC_IF, found, RPC); end
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (Instr_PC_IF !== RPC + 32'd4 || Instr_Valid_IF !== 1'b1) begin
         errors++; $display("FAIL ack_second_pc got %h valid=%b want %h", Instr_PC_IF, Instr_Valid_IF, RPC + 32'd4);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_same_edge();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      test_ack_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
